// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// op encodings, FSM state type and the divide-by-zero result rule.
package muldiv_pkg;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  // Widest datapath the helper below supports; callers slice down to DATA_W.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Unsigned divide by zero: quotient is all ones, remainder is the dividend.
  function automatic logic [MAX_W-1:0] div_zero_result(input logic [1:0]       op,
                                                       input logic [MAX_W-1:0] dividend);
    return (op == OP_REMU) ? dividend : {MAX_W{1'b1}};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier or restoring divider.
// hi carries the product high word or the DATA_W+1 bit partial remainder.
module muldiv_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W:0]   hi,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] src_b,
  input  logic              is_div,
  output logic [DATA_W:0]   next_hi,
  output logic [DATA_W-1:0] next_lo
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] shifted_r;
  logic [DATA_W:0] diff;

  always_comb begin
    sum       = {1'b0, hi[DATA_W-1:0]} + (lo[0] ? {1'b0, src_b} : '0);
    shifted_r = {hi[DATA_W-1:0], lo[DATA_W-1]};
    diff      = shifted_r - {1'b0, src_b};
    if (is_div) begin
      // diff[DATA_W] set means the trial subtraction went negative: restore.
      next_hi = diff[DATA_W] ? shifted_r : diff;
      next_lo = {lo[DATA_W-2:0], ~diff[DATA_W]};
    end else begin
      next_hi = {1'b0, sum[DATA_W:1]};
      next_lo = {sum[0], lo[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Execute-stage mul/div sequencer: accepts an op, stalls the pipe for
// DATA_W iterations and presents the result for exactly one cycle.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [OP_W-1:0]   op_i,
  input  logic [DATA_W-1:0] src_a_i,
  input  logic [DATA_W-1:0] src_b_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              result_valid_o,
  output logic [DATA_W-1:0] result_o
);

  localparam int CNT_W = $clog2(DATA_W);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W:0]   hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] result_q;

  logic              accept;
  logic              div_zero;
  logic              last_iter;
  logic [DATA_W:0]   step_hi;
  logic [DATA_W-1:0] step_lo;
  logic [MAX_W-1:0]  dz_result;

  assign div_zero  = op_i[1] && (src_b_i == '0);
  assign last_iter = (count_q == CNT_W'(DATA_W - 1));
  assign dz_result = div_zero_result(2'(op_i), MAX_W'(src_a_i));

  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .hi      (hi_q),
    .lo      (lo_q),
    .src_b   (b_q),
    .is_div  (op_q[1]),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    stall_o = 1'b0;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid_i && !flush_i) begin
          accept  = 1'b1;
          stall_o = 1'b1;
          state_d = div_zero ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          stall_o = 1'b1;
          if (last_iter) state_d = ST_DONE;
        end
      end
      // valid_i is still high for the finished instruction; never restart from DONE.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (!reset) stall_o = 1'b0;
  end

  assign busy_o         = (state_q != ST_IDLE);
  assign result_valid_o = (state_q == ST_DONE) && !flush_i;
  assign result_o       = result_q;

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      op_q     <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= op_i;
        b_q     <= src_b_i;
        hi_q    <= '0;
        lo_q    <= src_a_i;
        count_q <= '0;
        if (div_zero) result_q <= dz_result[DATA_W-1:0];
      end else if (state_q == ST_RUN && !flush_i) begin
        hi_q    <= step_hi;
        lo_q    <= step_lo;
        count_q <= count_q + 1'b1;
        // op[0] picks the high half: MULHU's high word, REMU's remainder.
        if (last_iter) result_q <= op_q[0] ? step_hi[DATA_W-1:0] : step_lo;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_muldiv_ctrl;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         valid_i = 1'b0;
  logic         flush_i = 1'b0;
  logic [1:0]   op_i = 2'b00;
  logic [W-1:0] src_a_i = '0;
  logic [W-1:0] src_b_i = '0;
  logic         stall_o, busy_o, result_valid_o;
  logic [W-1:0] result_o;

  int tests = 0;
  int fails = 0;

  muldiv_ctrl #(.DATA_W(W), .OP_W(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_i        (valid_i),
    .op_i           (op_i),
    .src_a_i        (src_a_i),
    .src_b_i        (src_b_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .busy_o         (busy_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", name, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint unsigned p;
    p = longint'(a) * longint'(b);
    case (op)
      2'b00:   return p[W-1:0];
      2'b01:   return p[2*W-1:W];
      2'b10:   return (b == 0) ? '1 : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one op and follows it to its DONE cycle; leaves valid_i high there.
  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit scramble);
    int cyc;
    int gaps;
    int exp_lat;
    exp_lat = (op[1] && b == 0) ? 1 : W + 1;
    valid_i = 1'b1;
    op_i    = op;
    src_a_i = a;
    src_b_i = b;
    #1;
    if (result_valid_o === 1'b1) step();
    check_bit({name, " idle before accept"}, busy_o, 1'b0);
    cyc  = 0;
    gaps = 0;
    while (result_valid_o !== 1'b1 && cyc < 100) begin
      if (stall_o !== 1'b1) gaps++;
      step();
      cyc++;
      if (scramble) begin
        src_a_i = $urandom;
        src_b_i = $urandom;
        #1;
      end
    end
    check({name, " stall cycles"}, W'(cyc), W'(exp_lat));
    check({name, " stall gaps"}, W'(gaps), '0);
    check({name, " result"}, result_o, ref_result(op, a, b));
    check_bit({name, " stall in done"}, stall_o, 1'b0);
    check_bit({name, " busy in done"}, busy_o, 1'b1);
  endtask

  task automatic end_op(input string name);
    valid_i = 1'b0;
    step();
    check_bit({name, " valid one cycle"}, result_valid_o, 1'b0);
    check_bit({name, " busy after"}, busy_o, 1'b0);
  endtask

  initial begin
    int seen;
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;

    // Reset with valid_i high: stall_o must stay low.
    valid_i = 1'b1;
    step();
    step();
    check_bit("reset stall", stall_o, 1'b0);
    check_bit("reset busy", busy_o, 1'b0);
    check_bit("reset valid", result_valid_o, 1'b0);
    check("reset result", result_o, '0);
    valid_i = 1'b0;
    reset   = 1'b1;
    step();

    run_op("mul 7x6", 2'b00, 32'd7, 32'd6, 1'b0);
    end_op("mul 7x6");
    run_op("mulhu ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("mulhu ff const", result_o, 32'hFFFF_FFFE);
    end_op("mulhu ff");
    run_op("mul ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("mul ff const", result_o, 32'h0000_0001);
    end_op("mul ff");
    run_op("divu 100/7", 2'b10, 32'd100, 32'd7, 1'b0);
    check("divu const", result_o, 32'd14);
    end_op("divu 100/7");
    run_op("remu 100/7", 2'b11, 32'd100, 32'd7, 1'b0);
    check("remu const", result_o, 32'd2);
    end_op("remu 100/7");
    run_op("divu 5/0", 2'b10, 32'd5, 32'd0, 1'b0);
    end_op("divu 5/0");
    run_op("remu 5/0", 2'b11, 32'd5, 32'd0, 1'b0);
    end_op("remu 5/0");

    // Flush on the 10th RUN cycle.
    valid_i = 1'b1; op_i = 2'b00; src_a_i = 32'd3; src_b_i = 32'd9;
    step();
    repeat (9) step();
    flush_i = 1'b1;
    #1;
    check_bit("flush run10 stall", stall_o, 1'b0);
    check_bit("flush run10 valid", result_valid_o, 1'b0);
    step();
    flush_i = 1'b0; valid_i = 1'b0;
    #1;
    check_bit("flush run10 idle", busy_o, 1'b0);
    seen = 0;
    repeat (40) begin
      step();
      if (result_valid_o !== 1'b0 || busy_o !== 1'b0) seen++;
    end
    check("flush run10 no result", W'(seen), '0);

    // Flush coinciding with the final RUN cycle.
    valid_i = 1'b1; op_i = 2'b10; src_a_i = 32'd77; src_b_i = 32'd5;
    step();
    repeat (W - 1) step();
    check_bit("flush last still run", busy_o, 1'b1);
    flush_i = 1'b1;
    #1;
    check_bit("flush last stall", stall_o, 1'b0);
    step();
    flush_i = 1'b0; valid_i = 1'b0;
    #1;
    check_bit("flush last no done", result_valid_o, 1'b0);
    check_bit("flush last idle", busy_o, 1'b0);

    // flush_i with valid_i in IDLE blocks acceptance.
    valid_i = 1'b1; flush_i = 1'b1;
    #1;
    check_bit("idle flush stall", stall_o, 1'b0);
    step();
    check_bit("idle flush busy", busy_o, 1'b0);
    flush_i = 1'b0; valid_i = 1'b0;
    step();

    // Reset mid-RUN.
    valid_i = 1'b1; op_i = 2'b01; src_a_i = 32'h1234_5678; src_b_i = 32'h9ABC_DEF0;
    step();
    repeat (5) step();
    reset = 1'b0;
    #1;
    check_bit("mid reset stall", stall_o, 1'b0);
    step();
    check_bit("mid reset busy", busy_o, 1'b0);
    check_bit("mid reset valid", result_valid_o, 1'b0);
    check("mid reset result", result_o, '0);
    reset = 1'b1; valid_i = 1'b0;
    step();

    // Back-to-back with operands changing after acceptance.
    run_op("b2b divu", 2'b10, 32'd1000, 32'd33, 1'b1);
    run_op("b2b mul", 2'b00, 32'd12345, 32'd678, 1'b1);
    end_op("b2b");

    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(3));
      ra  = $urandom;
      rb  = ($urandom_range(3) == 0) ? '0 : $urandom >> $urandom_range(31);
      run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, 1'b1);
      if ($urandom_range(1) == 0) end_op($sformatf("rand%0d", i));
    end
    end_op("rand tail");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
